// File: rtl/serial_adder_ctrl_if.sv
// Requester-side bundle for the bit-serial adder controller.
// Optional subtract select is present only when SERIAL_ADD_SUB_EN is defined.
// Handshake: the requester raises start with a/b/cin (and sub) stable; the
// operands are captured on the rising edge where start=1 and the controller is
// idle or done. busy is high for WIDTH cycles, then done pulses for one cycle
// with sum/cout valid; sum/cout hold until the next result completes.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [1:0]       dbg_state;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, dbg_state);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, dbg_state);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, dbg_state);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, dbg_state);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced over WIDTH cycles, LSB first.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the sub input; sub=1 computes
// a - b by loading ~b with a forced initial carry of 1).
// The FSM state is exposed on bus.dbg_state (0=IDLE, 1=RUN, 2=DONE).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             sub_w;
  logic             cell_s;
  logic             cell_c;
  logic [WIDTH-1:0] r_next;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_w = bus.sub;
`else
  assign sub_w = 1'b0;
`endif

  // The single shared full-adder cell and the result shift-in (new bit enters at MSB)
  always_comb begin
    cell_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    cell_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    r_next = (r_sh_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
  end

  // Next-state and datapath updates; accept from IDLE or DONE, step in RUN
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          b_sh_d  = sub_w ? ~bus.b : bus.b;
          carry_d = sub_w ? 1'b1 : bus.cin;
          r_sh_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        r_sh_d  = r_next;
        carry_d = cell_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          sum_d   = r_next;
          cout_d  = cell_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// A latency-level model predicts busy/done/sum/cout every cycle; directed
// operations additionally check results against hand-computed literals.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted op keeps busy high for W cycles, then done for one cycle with
  // {cout,sum} = a + b + cin (or a + ~b + 1 when subtracting).
  int         m_left;
  logic       m_done;
  logic [W:0] m_pend;
  logic [W:0] m_res;

  function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  function automatic logic cur_sub();
`ifdef SERIAL_ADD_SUB_EN
    return bus.sub;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_pend = '0;
      m_res  = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_res  = m_pend;
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        m_pend = golden(bus.a, bus.b, bus.cin, cur_sub());
        m_left = W;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    chk("cyc_busy", 64'(bus.busy), 64'(m_left > 0));
    chk("cyc_done", 64'(bus.done), 64'(m_done));
    chk("cyc_sum",  64'(bus.sum),  64'(m_res[W-1:0]));
    chk("cyc_cout", 64'(bus.cout), 64'(m_res[W]));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: sub requested without subtract support");
`endif
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub);
    @(negedge clk);
    drive(a, b, cin, sub);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [W:0] exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk({name, "_timeout"}, 64'(0), 64'(1));
    else chk(name, 64'({bus.cout, bus.sum}), 64'(exp));
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] vals [16];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    vals = '{8'h00, 8'h01, 8'h02, 8'h0E, 8'h0F, 8'h10, 8'h3C, 8'h55,
             8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_sum",  64'(bus.sum),  64'(0));
    chk("rst_cout", 64'(bus.cout), 64'(0));
    rst_n = 1'b1;

    // Basic add with busy-length check
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    begin
      int busy_cnt;
      busy_cnt = 0;
      for (int i = 0; i < 20 && !bus.done; i++) begin
        if (bus.busy) busy_cnt++;
        @(negedge clk);
      end
      chk("basic_busy_cycles", 64'(busy_cnt), 64'(8));
    end
    wait_done("basic_add", 9'h010);

    // Carry ripple
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done("ripple_ff_01", 9'h100);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done("ripple_ff_ff_c", 9'h1FF);

    // start during RUN ignored
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(8'hAA, 8'h55, 1'b1, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_run_start", 9'h010);

    // Back-to-back accept from DONE; old result held until new done
    drive(8'h20, 8'h22, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'(1));
    chk("b2b_held_sum", 64'(bus.sum), 64'(8'h10));
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    wait_done("b2b_result", 9'h042);

    // Reset in the middle of an operation
    issue(8'hAB, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_done", 64'(bus.done), 64'(0));
    chk("mid_rst_sum",  64'(bus.sum),  64'(0));
    chk("mid_rst_cout", 64'(bus.cout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    wait_done("post_rst_add", 9'h046);

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done("sub_5_7", 9'h0FE);
    issue(8'h07, 8'h05, 1'b0, 1'b1);
    wait_done("sub_7_5", 9'h102);
    issue(8'h07, 8'h05, 1'b1, 1'b0);
    wait_done("sub0_add", 9'h00D);
`endif

    // Boundary sweep over edge-case operand values, both carries
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int c = 0; c < 2; c++) begin
          issue(vals[i], vals[j], c[0], 1'b0);
          wait_done("sweep", {1'b0, vals[i]} + {1'b0, vals[j]} + 9'(c));
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
